bus_master_port: RTL
====================

Name: bus_master_port

Overview:
- Master-side bus interface that sits directly upstream of the bus arbiter, one instance per master (m1, m2).
- Accepts a parallel transaction from the master core, raises the bus request and serialises the 2-bit slave select onto the arbiter's slave-select line.
- After grant, sends the address (and write data) bit-serially to the selected slave, or collects read data bit-serially.
- Tolerates grant withdrawal during a slave split and resumes where it stopped.

Parameters:
- ADDR_WIDTH, 12, address bits sent serially, LSB first.
- DATA_WIDTH, 8, data bits sent/received serially, LSB first.
- TIMEOUT, 255, max cycles in WAIT_DONE/RDATA without progress before abort; minimum 1.

Ports:
- sys_clk  in  1  system clock, all logic on rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- start  in  1  core pulse: begin transaction; sampled only in IDLE.
- rw  in  1  1 = write, 0 = read; latched at start.
- slave_id  in  2  target slave (1..3); latched at start.
- addr  in  ADDR_WIDTH  target address; latched at start.
- wdata  in  DATA_WIDTH  write data; latched at start.
- rdata  out  DATA_WIDTH  read result; valid when done=1 and rw latched 0.
- done  out  1  one-cycle pulse: transaction complete.
- error  out  1  one-cycle pulse: transaction aborted by timeout.
- busy  out  1  high from the cycle after start until the cycle after done/error.
- m_request  out  1  bus request to arbiter.
- m_slave_sel  out  1  serial slave-select bit to arbiter.
- m_grant  in  1  grant from arbiter.
- m_rw  out  1  latched rw, driven while granted.
- m_dout  out  1  serial address/write-data bit.
- m_dout_valid  out  1  m_dout qualifier.
- m_din  in  1  serial read-data bit from slave.
- m_din_valid  in  1  m_din qualifier.
- trans_done  in  1  slave completion strobe (shared with arbiter).

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Applies immediately and at any point mid-transaction; the transaction is lost and no done/error pulse is issued.
- States: IDLE, SEL0, SEL1, WAIT_GRANT, ADDR, WDATA, RDATA, WAIT_DONE, FINISH.
- IDLE: start=1 latches rw, slave_id, addr and wdata, then enters SEL0. start in any other state is ignored.
- SEL0: m_request=1, m_slave_sel=slave_id[0]. Next state is SEL1.
- SEL1: m_request=1, m_slave_sel=slave_id[1]. Next state is WAIT_GRANT. The arbiter samples bit0 in the first request cycle and bit1 in the next, so this two-cycle order is mandatory.
- WAIT_GRANT: m_request=1, m_slave_sel=0. When m_grant=1, go to ADDR with the bit counter at 0. No timeout in this state.
- ADDR: when m_grant=1, drive m_dout=addr[cnt] and m_dout_valid=1, then increment cnt.
  - After bit ADDR_WIDTH-1: go to WDATA if write, else RDATA; cnt resets to 0.
- WDATA: same bit-send scheme over wdata, DATA_WIDTH bits. Then go to WAIT_DONE.
- Grant loss (split) in ADDR or WDATA:
  - m_dout_valid=0 and cnt frozen while m_grant=0.
  - Sending resumes at the same bit when m_grant returns.
  - m_request stays 1 throughout.
- RDATA: each cycle with m_grant=1 and m_din_valid=1 shifts m_din into rdata_shift[cnt] and increments cnt.
  - After DATA_WIDTH bits: go to WAIT_DONE.
  - trans_done arriving before all bits are collected: go to FINISH with the partial data (missing bits 0).
- WAIT_DONE: trans_done=1 moves to FINISH.
- Timeout:
  - A timeout counter runs in RDATA and WAIT_DONE. It counts cycles without m_din_valid or trans_done and clears on each valid bit.
  - Reaching TIMEOUT: m_request drops, error pulses, state returns to IDLE.
  - The counter freezes while m_grant=0.
- FINISH: m_request=0, done=1 for exactly one cycle. rdata is registered from the shift register (reads only; rdata holds otherwise). Next state is IDLE.
- m_request: 1 from SEL0 through WAIT_DONE inclusive. It drops in the cycle after trans_done is seen, so the arbiter returns to idle.
- m_rw: equals latched rw in ADDR..WAIT_DONE, else 0.
- busy: 1 in SEL0..FINISH.
- trans_done outside RDATA/WAIT_DONE is ignored.
- m_din_valid without m_grant is ignored.
- A simultaneous last read bit and trans_done captures the bit and goes to FINISH.

Test Plan:
- Write, no contention: start with rw=1, slave_id=2, addr=0x0A5, wdata=0x3C, grant 2 cycles after SEL1.
  - Required: m_slave_sel sequence 0,1.
  - Then 12 address bits 1,0,1,0,0,1,0,1,0,0,0,0 with valid=1.
  - Then 8 data bits 0,0,1,1,1,1,0,0.
  - trans_done leads to done pulse 1 cycle later; m_request low.
- Read: rw=0, slave_id=1, addr=0x001, slave returns bits of 0xA7 with valid gaps → rdata=0xA7 on the done cycle; rdata unchanged after.
- Split mid-address: m_grant drops after addr bit 5 for 10 cycles → m_dout_valid low for exactly those 10 cycles, bit 6 sent first on regrant, m_request stays 1, total 12 valid address bits.
- Timeout: TIMEOUT=16 read, no m_din_valid/trans_done after address → error pulse on the 16th idle cycle, no done pulse, busy low the cycle after, m_request 0.
- Reset mid-WDATA: sys_rst_n low asynchronously → all outputs 0 without a clock edge; after release, a new start behaves as in the write scenario.
- start pulses while busy are ignored; back-to-back start on the cycle after done is accepted, and m_slave_sel restarts at SEL0.

Source files
------------

// File: rtl/bus_master_port.sv
// bus_master_port: master-side bus port; serialises slave select, requests the bus,
// then sends address/write data or collects read data bit-serially, resuming after splits.
module bus_master_port #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  start,
    input  logic                  rw,
    input  logic [1:0]            slave_id,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  done,
    output logic                  error,
    output logic                  busy,
    output logic                  m_request,
    output logic                  m_slave_sel,
    input  logic                  m_grant,
    output logic                  m_rw,
    output logic                  m_dout,
    output logic                  m_dout_valid,
    input  logic                  m_din,
    input  logic                  m_din_valid,
    input  logic                  trans_done
);
    localparam int MW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CW = $clog2(MW + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        IDLE, SEL0, SEL1, WAIT_GRANT, ADDR, WDATA, RDATA, WAIT_DONE, FINISH
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [TW-1:0]         tcnt_q, tcnt_d;
    logic                  rw_q, rw_d;
    logic [1:0]            sid_q, sid_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rd_bit;

    assign rd_bit = (state_q == RDATA) && m_grant && m_din_valid;
    assign rdata  = rdata_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tcnt_q  <= '0;
            rw_q    <= 1'b0;
            sid_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            shift_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tcnt_q  <= tcnt_d;
            rw_q    <= rw_d;
            sid_q   <= sid_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            shift_q <= shift_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tcnt_d       = '0;
        rw_d         = rw_q;
        sid_d        = sid_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        shift_d      = shift_q;
        done         = 1'b0;
        error        = 1'b0;
        busy         = state_q != IDLE;
        m_request    = 1'b0;
        m_slave_sel  = 1'b0;
        m_rw         = 1'b0;
        m_dout       = 1'b0;
        m_dout_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    rw_d    = rw;
                    sid_d   = slave_id;
                    addr_d  = addr;
                    wdata_d = wdata;
                    shift_d = '0;
                    cnt_d   = '0;
                    state_d = SEL0;
                end
            end
            SEL0: begin
                m_request   = 1'b1;
                m_slave_sel = sid_q[0];
                state_d     = SEL1;
            end
            SEL1: begin
                m_request   = 1'b1;
                m_slave_sel = sid_q[1];
                state_d     = WAIT_GRANT;
            end
            WAIT_GRANT: begin
                m_request = 1'b1;
                if (m_grant) begin
                    cnt_d   = '0;
                    state_d = ADDR;
                end
            end
            // Both send phases shift their register down; without grant nothing moves.
            ADDR, WDATA: begin
                m_request = 1'b1;
                m_rw      = rw_q;
                if (m_grant) begin
                    m_dout_valid = 1'b1;
                    m_dout       = (state_q == ADDR) ? addr_q[0] : wdata_q[0];
                    cnt_d        = cnt_q + 1'b1;
                    if (state_q == ADDR) begin
                        addr_d = addr_q >> 1;
                        if (cnt_q == CW'(ADDR_WIDTH - 1)) begin
                            cnt_d   = '0;
                            state_d = rw_q ? WDATA : RDATA;
                        end
                    end else begin
                        wdata_d = wdata_q >> 1;
                        if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                            cnt_d   = '0;
                            state_d = WAIT_DONE;
                        end
                    end
                end
            end
            RDATA, WAIT_DONE: begin
                m_request = 1'b1;
                m_rw      = rw_q;
                tcnt_d    = tcnt_q;
                if (rd_bit) begin
                    shift_d = shift_q | (DATA_WIDTH'(m_din) << cnt_q);
                    cnt_d   = cnt_q + 1'b1;
                    tcnt_d  = '0;
                    if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                        cnt_d   = '0;
                        state_d = WAIT_DONE;
                    end
                end
                if (trans_done) begin
                    state_d = FINISH;
                end else if (m_grant && !rd_bit) begin
                    if (tcnt_q == TW'(TIMEOUT - 1)) begin
                        error     = 1'b1;
                        m_request = 1'b0;
                        tcnt_d    = '0;
                        state_d   = IDLE;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
            FINISH: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Load rdata on the way into FINISH so the value is already valid during the done pulse.
    always_comb begin
        rdata_d = (state_d == FINISH && state_q != FINISH && !rw_q) ? shift_d : rdata_q;
    end
endmodule
